reg_pipe_sv: RTL and testbench

Parametrised elastic pipeline register: a chain of DEPTH data stages with valid/ready handshake, bubble collapsing, synchronous flush and an optional input skid buffer that registers the upstream ready. It is the next generation of the single register primitives. It sits between peripheral datapath blocks that need configurable latency, back-pressure and a flush, such as bus bridges and FIFO front ends.

---
 rtl/reg_pipe_sv_if.sv | 12 +
 rtl/reg_pipe_sv.sv | 103 ++++++++++
 tb/tb_reg_pipe_sv.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_pipe_sv_if.sv
// Valid/ready/data handshake bundle for one side of the elastic pipeline.
// The master drives valid and data, the slave answers with ready.
interface reg_pipe_sv_if #(
  parameter int DATA_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/reg_pipe_sv.sv
// Elastic pipeline register: DEPTH valid/data stages with bubble collapsing,
// synchronous flush and an optional input skid entry that registers upstream ready.
module reg_pipe_sv #(
  parameter int    DATA_W = 8,
  parameter int    DEPTH  = 2,
  parameter string MODE   = "FWD",
  localparam int   CNT_W  = $clog2(DEPTH + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  reg_pipe_sv_if.slave     up,
  reg_pipe_sv_if.master    dn,
  output logic [CNT_W-1:0] count
);

  localparam bit SKID = (MODE == "SKID");

  logic [DEPTH-1:0]  v_reg;
  logic [DEPTH-1:0]  v_next;
  logic [DEPTH-1:0]  in_v;
  logic [DEPTH-1:0]  rdy;
  logic [DEPTH-1:0]  d_load;
  logic [DATA_W-1:0] d_reg [DEPTH];
  logic [DATA_W-1:0] in_d  [DEPTH];
  logic              sv_reg;
  logic              sv_next;
  logic [DATA_W-1:0] sd_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      // A stage can take new data when the output drains or any stage at or after it is empty.
      assign rdy[gi] = dn.ready | ~(&v_reg[DEPTH-1:gi]);

      if (gi == 0) begin : g_head
        assign in_v[gi] = sv_reg | up.valid;
        assign in_d[gi] = sv_reg ? sd_reg : up.data;
      end else begin : g_body
        assign in_v[gi] = v_reg[gi-1];
        assign in_d[gi] = d_reg[gi-1];
      end

      assign v_next[gi] = clr ? 1'b0 : (rdy[gi] ? in_v[gi] : v_reg[gi]);
      assign d_load[gi] = ~clr & rdy[gi] & in_v[gi];
    end

    if (SKID) begin : g_skid
      // The skid entry catches a beat accepted while stage 0 is stalled.
      assign sv_next  = ~clr & ~rdy[0] & (sv_reg | up.valid);
      assign up.ready = ~sv_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sv_reg <= 1'b0;
          sd_reg <= '0;
        end else begin
          sv_reg <= sv_next;
          if (~clr & ~sv_reg & up.valid & ~rdy[0]) begin
            sd_reg <= up.data;
          end
        end
      end
    end else begin : g_fwd
      assign sv_reg   = 1'b0;
      assign sv_next  = 1'b0;
      assign sd_reg   = '0;
      assign up.ready = rdy[0];
    end
  endgenerate

  always_comb begin
    count_next = CNT_W'(sv_next);
    for (int i = 0; i < DEPTH; i++) begin
      count_next = count_next + CNT_W'(v_next[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_reg     <= '0;
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_reg[i] <= '0;
      end
    end else begin
      v_reg     <= v_next;
      count_reg <= count_next;
      for (int i = 0; i < DEPTH; i++) begin
        if (d_load[i]) begin
          d_reg[i] <= in_d[i];
        end
      end
    end
  end

  assign dn.valid = v_reg[DEPTH-1];
  assign dn.data  = d_reg[DEPTH-1];
  assign count    = count_reg;

endmodule

// File: tb/tb_reg_pipe_sv.sv
// Bench for reg_pipe_sv: three instances (FWD depth 3, SKID depth 3, FWD depth 4) share one
// stimulus and are compared every cycle against a queue-of-entries model with positions.
module tb_reg_pipe_sv;

  logic       clk;
  logic       rst_n;
  logic       clr_s;
  logic       valid_s;
  logic [7:0] data_s;
  logic       ordy_s;

  int checks = 0;
  int errors = 0;

  reg_pipe_sv_if #(.DATA_W(8)) up0 ();
  reg_pipe_sv_if #(.DATA_W(8)) dn0 ();
  reg_pipe_sv_if #(.DATA_W(8)) up1 ();
  reg_pipe_sv_if #(.DATA_W(8)) dn1 ();
  reg_pipe_sv_if #(.DATA_W(8)) up2 ();
  reg_pipe_sv_if #(.DATA_W(8)) dn2 ();

  logic [2:0] cnt0, cnt1, cnt2;

  assign up0.valid = valid_s;  assign up0.data = data_s;  assign dn0.ready = ordy_s;
  assign up1.valid = valid_s;  assign up1.data = data_s;  assign dn1.ready = ordy_s;
  assign up2.valid = valid_s;  assign up2.data = data_s;  assign dn2.ready = ordy_s;

  reg_pipe_sv #(.DATA_W(8), .DEPTH(3), .MODE("FWD")) u_fwd3 (
    .clk(clk), .rst_n(rst_n), .clr(clr_s), .up(up0.slave), .dn(dn0.master), .count(cnt0));
  reg_pipe_sv #(.DATA_W(8), .DEPTH(3), .MODE("SKID")) u_skid3 (
    .clk(clk), .rst_n(rst_n), .clr(clr_s), .up(up1.slave), .dn(dn1.master), .count(cnt1));
  reg_pipe_sv #(.DATA_W(8), .DEPTH(4), .MODE("FWD")) u_fwd4 (
    .clk(clk), .rst_n(rst_n), .clr(clr_s), .up(up2.slave), .dn(dn2.master), .count(cnt2));

  logic       obs_ir  [3];
  logic       obs_ov  [3];
  logic [7:0] obs_od  [3];
  logic [2:0] obs_cnt [3];

  assign obs_ir[0] = up0.ready;  assign obs_ov[0] = dn0.valid;  assign obs_od[0] = dn0.data;
  assign obs_ir[1] = up1.ready;  assign obs_ov[1] = dn1.valid;  assign obs_od[1] = dn1.data;
  assign obs_ir[2] = up2.ready;  assign obs_ov[2] = dn2.valid;  assign obs_od[2] = dn2.data;
  assign obs_cnt[0] = cnt0;  assign obs_cnt[1] = cnt1;  assign obs_cnt[2] = cnt2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: per instance, an ordered list of held entries (oldest first) with a position;
  // position -1 is the skid slot, DEPTH-1 is the output stage.
  int qd [3][8];
  int qp [3][8];
  int qn [3];

  function automatic int dep_of(input int m);
    return (m == 2) ? 4 : 3;
  endfunction

  function automatic bit skid_of(input int m);
    return (m == 1);
  endfunction

  function automatic bit m_ov(input int m);
    if (qn[m] == 0) return 1'b0;
    return (qp[m][0] == dep_of(m) - 1);
  endfunction

  function automatic bit m_ir(input int m);
    int nst;
    nst = 0;
    for (int k = 0; k < qn[m]; k++) if (qp[m][k] >= 0) nst++;
    if (skid_of(m)) begin
      if (qn[m] == 0) return 1'b1;
      return (qp[m][qn[m]-1] != -1);
    end
    return ordy_s || (nst < dep_of(m));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic model_step(input int m);
    int  d;
    int  n;
    bit  acc;
    int  np [8];
    d   = dep_of(m);
    acc = valid_s && m_ir(m);
    if (!rst_n || clr_s) begin
      qn[m] = 0;
      return;
    end
    n = qn[m];
    if (acc) begin
      qd[m][n] = int'(data_s);
      qp[m][n] = -1;
      n++;
    end
    // Entry k moves up unless every slot between it and the output is taken and output stalls.
    for (int k = 0; k < n; k++) begin
      np[k] = (ordy_s || (k < d - 1 - qp[m][k])) ? qp[m][k] + 1 : qp[m][k];
    end
    if (n > 0 && np[0] == d) begin
      for (int k = 1; k < n; k++) begin
        qd[m][k-1] = qd[m][k];
        np[k-1]    = np[k];
      end
      n--;
    end
    for (int k = 0; k < n; k++) qp[m][k] = np[k];
    qn[m] = n;
  endtask

  // One clock cycle: drive inputs just after a rising edge, probe skid ready isolation,
  // compare everything on the falling edge, then advance the model.
  task automatic cycle(input bit v, input logic [7:0] d, input bit r, input bit c);
    logic ir_a, ir_b;
    valid_s = v;  data_s = d;  ordy_s = r;  clr_s = c;
    #1 ir_a = obs_ir[1];
    ordy_s = ~r;
    #1 ir_b = obs_ir[1];
    ordy_s = r;
    #1;
    chk("skid_iso", ir_b, ir_a);
    @(negedge clk);
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("ir%0d", m), obs_ir[m], m_ir(m));
      chk($sformatf("ov%0d", m), obs_ov[m], m_ov(m));
      if (m_ov(m)) chk($sformatf("od%0d", m), obs_od[m], qd[m][0]);
      chk($sformatf("cnt%0d", m), obs_cnt[m], qn[m]);
      model_step(m);
    end
    $display("cyc v=%0d d=%02h r=%0d c=%0d | cnt %0d/%0d/%0d", v, d, r, c, qn[0], qn[1], qn[2]);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("%s_ir%0d", tag, m), obs_ir[m], 1);
      chk($sformatf("%s_ov%0d", tag, m), obs_ov[m], 0);
      chk($sformatf("%s_od%0d", tag, m), obs_od[m], 0);
      chk($sformatf("%s_cnt%0d", tag, m), obs_cnt[m], 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat [3];
    logic [7:0]  rec [$];

    for (int m = 0; m < 3; m++) qn[m] = 0;
    rst_n = 1'b0;  clr_s = 1'b0;  valid_s = 1'b0;  data_s = 8'h00;  ordy_s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    // Stream through FWD depth 3 with the output always ready.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 8'(i + 1), 1'b1, 1'b0);
      if (i >= 2) begin
        chk("stream_od", obs_od[0], i - 1);
        chk("stream_cnt", obs_cnt[0], 3);
      end
    end
    repeat (6) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Back-pressure: fill every instance, then drain and collect the skid instance output.
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    chk("bp_ir_skid", obs_ir[1], 0);
    chk("bp_cnt_skid", obs_cnt[1], 4);
    chk("bp_cnt_fwd3", obs_cnt[0], 3);
    chk("bp_cnt_fwd4", obs_cnt[2], 4);
    for (int i = 0; i < 8; i++) begin
      if (obs_ov[1]) rec.push_back(obs_od[1]);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("bp_nout", rec.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < rec.size()) chk($sformatf("bp_out%0d", k), rec[k], 8'h20 + k);
    end

    // Bubble collapse: a lone beat walks to the end of a stalled pipe.
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("bub_ov", obs_ov[2], 1);
    chk("bub_od", obs_od[2], 8'h55);
    chk("bub_cnt", obs_cnt[2], 1);
    chk("bub_ir", obs_ir[2], 1);
    repeat (6) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush with a simultaneous input and output transfer.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    chk("fl_pre_cnt", obs_cnt[0], 3);
    chk("fl_pre_od", obs_od[0], 8'h60);
    cycle(1'b1, 8'hEE, 1'b1, 1'b1);
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("fl_cnt%0d", m), obs_cnt[m], 0);
      chk($sformatf("fl_ov%0d", m), obs_ov[m], 0);
    end
    repeat (5) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset mid-stream, between clock edges.
    for (int i = 0; i < 2; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("mid");
    for (int m = 0; m < 3; m++) qn[m] = 0;
    @(posedge clk);
    #1;
    cycle(1'b1, 8'h99, 1'b1, 1'b0);
    rst_n = 1'b1;
    cycle(1'b1, 8'hA5, 1'b1, 1'b0);
    for (int m = 0; m < 3; m++) lat[m] = 0;
    for (int k = 1; k <= 8; k++) begin
      for (int m = 0; m < 3; m++) begin
        if (obs_ov[m] && obs_od[m] == 8'hA5 && lat[m] == 0) lat[m] = k;
      end
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    for (int m = 0; m < 3; m++) chk($sformatf("lat%0d", m), lat[m], dep_of(m));

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0, ($urandom % 32) == 0);
    end

    // Full load with the output ready toggling every cycle.
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'($urandom), i[0], 1'b0);
    repeat (8) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
